// File: rtl/i2s_pkg.sv
// Shared types for the I2S stream controller: FSM state encoding and
// channel indices into a packed stereo frame.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with occupancy count. Pushes when full and pops
// when empty are dropped, so the level never leaves 0..DEPTH.
module i2s_frame_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/i2s_stream_ctrl.sv
// Sequences the I2S master: buffers stereo frames, updates the audio words on
// each right-word start seen on RightNLeft, and starts/stops on frame edges.
module i2s_stream_ctrl
  import i2s_pkg::*;
#(
  parameter int DATASIZE    = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int UCNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATASIZE-1:0]             s_left,
  input  logic [DATASIZE-1:0]             s_right,
  output logic [DATASIZE-1:0]             leftAudio,
  output logic [DATASIZE-1:0]             rightAudio,
  output logic                            enable,
  input  logic                            RightNLeft,
  output logic                            running,
  output logic                            underrun,
  output logic [UCNT_W-1:0]               underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

  state_e                      state_q, state_d;
  logic                        rnl_s1_q, rnl_s2_q, rnl_dly_q;
  logic                        rise, fall;
  logic                        stop_pend_q, stop_pend_d;
  logic                        enable_q, enable_d;
  logic                        running_q, running_d;
  logic                        underrun_q, underrun_d;
  logic [DATASIZE-1:0]         left_q, left_d, right_q, right_d;
  logic [UCNT_W-1:0]           ucnt_q, ucnt_d;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0][DATASIZE-1:0]    in_frame, head_frame;

  assign rise = rnl_s2_q & ~rnl_dly_q;
  assign fall = ~rnl_s2_q & rnl_dly_q;

  assign s_ready      = ~fifo_full;
  assign fifo_push    = s_valid & ~fifo_full;
  assign leftAudio    = left_q;
  assign rightAudio   = right_q;
  assign enable       = enable_q;
  assign running      = running_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

  always_comb begin
    in_frame        = '0;
    in_frame[LEFT]  = s_left;
    in_frame[RIGHT] = s_right;
  end

  i2s_frame_fifo #(
    .WIDTH (2 * DATASIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_frame),
    .pop     (fifo_pop),
    .rd_data (head_frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // RightNLeft is BCLK-domain: two sync stages plus one delay for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnl_s1_q  <= 1'b0;
      rnl_s2_q  <= 1'b0;
      rnl_dly_q <= 1'b0;
    end else begin
      rnl_s1_q  <= RightNLeft;
      rnl_s2_q  <= rnl_s1_q;
      rnl_dly_q <= rnl_s2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    enable_d    = enable_q;
    left_d      = left_q;
    right_d     = right_q;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        enable_d    = 1'b0;
        stop_pend_d = 1'b0;
        if (start) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (fifo_level >= PRIME_LVL) begin
          fifo_pop = 1'b1;
          left_d   = head_frame[LEFT];
          right_d  = head_frame[RIGHT];
          enable_d = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        // The master has just latched the left word, so both words may change.
        if (rise) begin
          if (stop_pend_q) begin
            left_d  = '0;
            right_d = '0;
            state_d = ST_STOPPING;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            left_d   = head_frame[LEFT];
            right_d  = head_frame[RIGHT];
          end else begin
            left_d     = '0;
            right_d    = '0;
            underrun_d = 1'b1;
            if (ucnt_q != '1) begin
              ucnt_d = ucnt_q + UCNT_W'(1);
            end else begin
              ucnt_d = ucnt_q;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STOPPING: begin
        if (fall) begin
          enable_d    = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_STOPPING;
        end
      end
      default: begin
        enable_d    = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      enable_q    <= 1'b0;
      running_q   <= 1'b0;
      underrun_q  <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      enable_q    <= enable_d;
      running_q   <= running_d;
      underrun_q  <= underrun_d;
      left_q      <= left_d;
      right_q     <= right_d;
      ucnt_q      <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Self-checking bench for i2s_stream_ctrl: a frame queue holds what the FIFO
// should contain and supplies the expected audio words on every rise.
module tb_i2s_stream_ctrl;

  logic        clk, rst, start, stop, s_valid, s_ready;
  logic [11:0] s_left, s_right, leftAudio, rightAudio;
  logic        enable, RightNLeft, running, underrun;
  logic [7:0]  underrun_cnt;
  logic [2:0]  fifo_level;

  logic [23:0] exp_q[$];
  int          n_cmp, n_bad, m_ucnt;
  logic [23:0] f;

  i2s_stream_ctrl #(
    .DATASIZE(12), .FIFO_DEPTH(4), .PRIME_LEVEL(2), .UCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .leftAudio(leftAudio), .rightAudio(rightAudio), .enable(enable),
    .RightNLeft(RightNLeft), .running(running), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [11:0] l, input logic [11:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    if (exp_q.size() < 4) exp_q.push_back({l, r});
    tick();
    s_valid = 1'b0;
  endtask

  // Raise RightNLeft; outputs update on the third clk. Optionally push a frame
  // so that it lands in the same cycle as the pop.
  task automatic rise_check(input bit stopping, input bit push_mid, input logic [23:0] pf);
    logic [23:0] e;
    logic        eu;
    bit          acc;
    RightNLeft = 1'b1;
    tick();
    tick();
    acc = push_mid && (exp_q.size() < 4);
    if (push_mid) begin
      s_valid = 1'b1;
      s_left  = pf[23:12];
      s_right = pf[11:0];
    end
    tick();
    s_valid = 1'b0;
    eu = 1'b0;
    if (stopping) begin
      e = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e  = '0;
      eu = 1'b1;
      if (m_ucnt < 255) m_ucnt++;
    end
    if (acc) exp_q.push_back(pf);
    check_eq("left_on_rise", leftAudio, e[23:12]);
    check_eq("right_on_rise", rightAudio, e[11:0]);
    check_eq("underrun_pulse", underrun, eu);
    check_eq("underrun_cnt", underrun_cnt, m_ucnt);
    check_eq("level_after_rise", fifo_level, exp_q.size());
    tick();
    check_eq("underrun_one_cycle", underrun, 1'b0);
  endtask

  task automatic fall_wait();
    RightNLeft = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_ucnt = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    s_left = '0; s_right = '0; RightNLeft = 1'b0;
    repeat (3) tick();
    check_eq("rst_enable", enable, 1'b0);
    check_eq("rst_left", leftAudio, 12'h000);
    check_eq("rst_right", rightAudio, 12'h000);
    check_eq("rst_running", running, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_ucnt", underrun_cnt, 8'd0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_ready", s_ready, 1'b1);
    rst = 1'b0;
    tick();

    start = 1'b1; tick(); start = 1'b0;
    check_eq("prime_running", running, 1'b1);
    check_eq("prime_enable", enable, 1'b0);
    push_frame(12'h123, 12'h456);
    check_eq("prime_level1", fifo_level, 3'd1);
    check_eq("prime_enable_lvl1", enable, 1'b0);
    push_frame(12'h789, 12'hABC);
    check_eq("prime_level2", fifo_level, 3'd2);
    check_eq("enable_not_yet", enable, 1'b0);
    tick();
    f = exp_q.pop_front();
    check_eq("enable_up", enable, 1'b1);
    check_eq("first_left", leftAudio, f[23:12]);
    check_eq("first_right", rightAudio, f[11:0]);
    check_eq("first_level", fifo_level, exp_q.size());

    rise_check(1'b0, 1'b0, 24'h0);
    fall_wait();
    for (int i = 0; i < 300; i++) begin
      rise_check(1'b0, 1'b0, 24'h0);
      fall_wait();
    end
    check_eq("ucnt_saturated", underrun_cnt, 8'd255);

    for (int i = 0; i < 4; i++) push_frame(12'($urandom), 12'($urandom));
    check_eq("full_level", fifo_level, 3'd4);
    check_eq("full_not_ready", s_ready, 1'b0);
    push_frame(12'h5A5, 12'hA5A);
    check_eq("full_push_dropped", fifo_level, 3'd4);
    rise_check(1'b0, 1'b0, 24'h0);
    fall_wait();
    rise_check(1'b0, 1'b1, 24'hDEF_321);
    fall_wait();

    stop = 1'b1; tick(); stop = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_pend_running", running, 1'b1);
    check_eq("stop_pend_enable", enable, 1'b1);
    rise_check(1'b1, 1'b0, 24'h0);
    check_eq("stopping_enable", enable, 1'b1);
    RightNLeft = 1'b0;
    tick(); tick();
    check_eq("stopping_enable_hold", enable, 1'b1);
    tick();
    check_eq("stopped_enable", enable, 1'b0);
    check_eq("stopped_running", running, 1'b0);
    check_eq("stopped_level", fifo_level, exp_q.size());

    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("start_wins", running, 1'b1);
    tick();
    f = exp_q.pop_front();
    check_eq("restart_enable", enable, 1'b1);
    check_eq("restart_left", leftAudio, f[23:12]);
    check_eq("restart_right", rightAudio, f[11:0]);
    push_frame(12'h0F0, 12'h00F);
    check_eq("run_level3", fifo_level, 3'd3);

    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("arst_enable", enable, 1'b0);
    check_eq("arst_left", leftAudio, 12'h000);
    check_eq("arst_right", rightAudio, 12'h000);
    check_eq("arst_level", fifo_level, 3'd0);
    check_eq("arst_ready", s_ready, 1'b1);
    check_eq("arst_running", running, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
